// File: rtl/kbd_pkg.sv
// kbd_pkg: PS/2 set-2 scancode constants, parser state encoding and command targets
// shared by the keyboard command parser and its digit decoder.
package kbd_pkg;

   localparam logic [7:0] SC_D0    = 8'h45;
   localparam logic [7:0] SC_D1    = 8'h16;
   localparam logic [7:0] SC_D2    = 8'h1E;
   localparam logic [7:0] SC_D3    = 8'h26;
   localparam logic [7:0] SC_D4    = 8'h25;
   localparam logic [7:0] SC_D5    = 8'h2E;
   localparam logic [7:0] SC_D6    = 8'h36;
   localparam logic [7:0] SC_D7    = 8'h3D;
   localparam logic [7:0] SC_D8    = 8'h3E;
   localparam logic [7:0] SC_D9    = 8'h46;
   localparam logic [7:0] SC_T     = 8'h2C;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_P     = 8'h4D;
   localparam logic [7:0] SC_G     = 8'h34;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHAN,
      ST_DIGITS,
      ST_FLAGV,
      ST_WAIT_ENT,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      TGT_ALERTA,
      TGT_PELIGRO,
      TGT_GAS,
      TGT_RESET
   } tgt_t;

endpackage

// File: rtl/scan_digit_dec.sv
// scan_digit_dec: maps a PS/2 set-2 scancode to its decimal digit value and an
// is-digit indication; non-digit codes decode to value 0 with o_is_digit low.
module scan_digit_dec
   import kbd_pkg::*;
(
   input  logic [7:0] i_code,
   output logic [3:0] o_val,
   output logic       o_is_digit
);

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_val      = 4'd0;
      o_is_digit = 1'b1;
      case (i_code)
         SC_D0:   o_val = 4'd0;
         SC_D1:   o_val = 4'd1;
         SC_D2:   o_val = 4'd2;
         SC_D3:   o_val = 4'd3;
         SC_D4:   o_val = 4'd4;
         SC_D5:   o_val = 4'd5;
         SC_D6:   o_val = 4'd6;
         SC_D7:   o_val = 4'd7;
         SC_D8:   o_val = 4'd8;
         SC_D9:   o_val = 4'd9;
         default: o_is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/kbd_cmd_parser.sv
// kbd_cmd_parser: parses PS/2 keyboard commands into temperature and status registers.
// Optional macro KBD_TIMEOUT_EN aborts a partial command after TIMEOUT_CYC idle cycles.
module kbd_cmd_parser
   import kbd_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int NDIG        = 3,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             flag,
   input  logic [7:0]       DATO,
   output logic [NCH*8-1:0] STtemp,
   output logic             STPeligro,
   output logic             STAlerta,
   output logic             STGas,
   output logic             Greset,
   output logic             cmd_err,
   output logic             busy
);

   localparam logic [3:0] NCH_L  = 4'(NCH);
   localparam logic [1:0] NDIG_L = 2'(NDIG);

   state_t            r_state, w_state_nx;
   tgt_t              r_tgt, w_tgt_nx;
   logic [9:0]        r_acc, w_acc_nx;
   logic [1:0]        r_ndig, w_ndig_nx;
   logic [3:0]        r_chan, w_chan_nx;
   logic              r_fval, w_fval_nx;
   logic              r_flag_prev, r_brk;
   logic [NCH*8-1:0]  r_sttemp;
   logic              r_peligro, r_alerta, r_gas, r_greset, r_cmd_err;
   logic              w_new, w_parse, w_wr_temp, w_wr_flag, w_greset, w_err, w_tmo_hit;
   logic [3:0]        w_dval;
   logic              w_is_digit;
   logic [7:0]        w_sat;

   scan_digit_dec u_dec (
      .i_code     (DATO),
      .o_val      (w_dval),
      .o_is_digit (w_is_digit)
   );

   assign w_new   = flag & ~r_flag_prev;
   // The byte after a break code and any extended prefix never reach the parser.
   assign w_parse = w_new && !r_brk && (DATO != SC_BREAK) && (DATO != SC_EXT);
   assign w_sat   = (r_acc > 10'd255) ? 8'hFF : r_acc[7:0];

`ifdef KBD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] r_tmo;

   assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)                                r_tmo <= '0;
      else if (w_new || r_state == ST_IDLE || w_tmo_hit) r_tmo <= '0;
      else                                         r_tmo <= r_tmo + 1'b1;
   end
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC > 0);
   assign w_tmo_hit    = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_tgt_nx   = r_tgt;
      w_acc_nx   = r_acc;
      w_ndig_nx  = r_ndig;
      w_chan_nx  = r_chan;
      w_fval_nx  = r_fval;
      w_wr_temp  = 1'b0;
      w_wr_flag  = 1'b0;
      w_greset   = 1'b0;
      w_err      = 1'b0;
      if (w_parse) begin
         unique case (r_state)
            ST_IDLE: begin
               w_acc_nx  = '0;
               w_ndig_nx = '0;
               case (DATO)
                  SC_T:     w_state_nx = ST_CHAN;
                  SC_A:     begin w_tgt_nx = TGT_ALERTA;  w_state_nx = ST_FLAGV;    end
                  SC_P:     begin w_tgt_nx = TGT_PELIGRO; w_state_nx = ST_FLAGV;    end
                  SC_G:     begin w_tgt_nx = TGT_GAS;     w_state_nx = ST_FLAGV;    end
                  SC_R:     begin w_tgt_nx = TGT_RESET;   w_state_nx = ST_WAIT_ENT; end
                  SC_ENTER: w_state_nx = ST_IDLE;
                  default:  w_state_nx = ST_ERR;
               endcase
            end
            ST_CHAN: begin
               if (w_is_digit && (w_dval != 4'd0) && (w_dval <= NCH_L)) begin
                  w_chan_nx  = w_dval - 4'd1;
                  w_state_nx = ST_DIGITS;
               end else begin
                  w_state_nx = ST_ERR;
               end
            end
            ST_DIGITS: begin
               if (w_is_digit) begin
                  if (r_ndig == NDIG_L) begin
                     w_state_nx = ST_ERR;
                  end else begin
                     w_acc_nx  = r_acc * 10'd10 + 10'(w_dval);
                     w_ndig_nx = r_ndig + 2'd1;
                  end
               end else if (DATO == SC_ENTER) begin
                  w_wr_temp  = (r_ndig != 2'd0);
                  w_err      = (r_ndig == 2'd0);
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx = ST_ERR;
               end
            end
            ST_FLAGV: begin
               if (DATO == SC_D0 || DATO == SC_D1) begin
                  w_fval_nx  = (DATO == SC_D1);
                  w_state_nx = ST_WAIT_ENT;
               end else begin
                  w_state_nx = ST_ERR;
               end
            end
            ST_WAIT_ENT: begin
               if (DATO == SC_ENTER) begin
                  w_greset   = (r_tgt == TGT_RESET);
                  w_wr_flag  = (r_tgt != TGT_RESET);
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx = ST_ERR;
               end
            end
            ST_ERR: begin
               if (DATO == SC_ENTER) begin
                  w_err      = 1'b1;
                  w_state_nx = ST_IDLE;
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end else if (w_tmo_hit && !w_new) begin
         w_err      = 1'b1;
         w_state_nx = ST_IDLE;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= ST_IDLE;
         r_tgt       <= TGT_ALERTA;
         r_acc       <= '0;
         r_ndig      <= '0;
         r_chan      <= '0;
         r_fval      <= 1'b0;
         r_flag_prev <= 1'b0;
         r_brk       <= 1'b0;
         r_sttemp    <= '0;
         r_peligro   <= 1'b0;
         r_alerta    <= 1'b0;
         r_gas       <= 1'b0;
         r_greset    <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_tgt       <= w_tgt_nx;
         r_acc       <= w_acc_nx;
         r_ndig      <= w_ndig_nx;
         r_chan      <= w_chan_nx;
         r_fval      <= w_fval_nx;
         r_flag_prev <= flag;
         r_greset    <= w_greset;
         r_cmd_err   <= w_err;
         if (w_new) r_brk <= !r_brk && (DATO == SC_BREAK);
         if (w_wr_temp) begin
            for (int k = 0; k < NCH; k++) begin
               if (r_chan == 4'(k)) r_sttemp[k*8 +: 8] <= w_sat;
            end
         end
         if (w_wr_flag) begin
            unique case (r_tgt)
               TGT_ALERTA:  r_alerta  <= r_fval;
               TGT_PELIGRO: r_peligro <= r_fval;
               TGT_GAS:     r_gas     <= r_fval;
               default:     ;
            endcase
         end
      end
   end

   assign STtemp    = r_sttemp;
   assign STPeligro = r_peligro;
   assign STAlerta  = r_alerta;
   assign STGas     = r_gas;
   assign Greset    = r_greset;
   assign cmd_err   = r_cmd_err;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_kbd_cmd_parser.sv
// tb_kbd_cmd_parser: directed scancode sequences; expected output events are queued by the
// stimulus and compared by an independent monitor whenever the DUT outputs change or pulse.
module tb_kbd_cmd_parser;

   typedef struct packed {
      logic        gr;
      logic        ce;
      logic [15:0] temp;
      logic [2:0]  flags;
   } ev_t;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        flag;
   logic [7:0]  DATO;
   logic [15:0] STtemp;
   logic        STPeligro, STAlerta, STGas, Greset, cmd_err, busy;

   ev_t         ev_q[$];
   string       name_q[$];
   logic [7:0]  seq[$];
   logic [15:0] m_temp;
   logic [2:0]  m_flags;
   int          n_tests = 0;
   int          n_fail  = 0;

   kbd_cmd_parser #(.NCH(2), .NDIG(3), .TIMEOUT_CYC(100)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .flag      (flag),
      .DATO      (DATO),
      .STtemp    (STtemp),
      .STPeligro (STPeligro),
      .STAlerta  (STAlerta),
      .STGas     (STGas),
      .Greset    (Greset),
      .cmd_err   (cmd_err),
      .busy      (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic expect_ev(input string name, input logic gr, input logic ce);
      ev_q.push_back('{gr: gr, ce: ce, temp: m_temp, flags: m_flags});
      name_q.push_back(name);
   endtask

   task automatic send(input logic [7:0] b, input int hold = 1);
      @(negedge CLK);
      DATO = b;
      flag = 1'b1;
      repeat (hold) @(negedge CLK);
      flag = 1'b0;
      @(negedge CLK);
   endtask

   task automatic run_seq();
      foreach (seq[i]) send(seq[i]);
   endtask

   // Monitor: any pulse or register change must match the oldest queued expectation.
   initial begin
      logic [15:0] mon_temp;
      logic [2:0]  mon_flags;
      ev_t         e;
      string       nm;
      mon_temp  = '0;
      mon_flags = '0;
      forever begin
         @(negedge CLK);
         if (!RESET_N) begin
            mon_temp  = STtemp;
            mon_flags = {STGas, STPeligro, STAlerta};
         end else if (Greset || cmd_err || STtemp != mon_temp ||
                      {STGas, STPeligro, STAlerta} != mon_flags) begin
            n_tests++;
            if (ev_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got gr=%0b ce=%0b temp=0x%0h flags=%b, none expected",
                        Greset, cmd_err, STtemp, {STGas, STPeligro, STAlerta});
            end else begin
               e  = ev_q.pop_front();
               nm = name_q.pop_front();
               if (Greset !== e.gr || cmd_err !== e.ce || STtemp !== e.temp ||
                   {STGas, STPeligro, STAlerta} !== e.flags) begin
                  n_fail++;
                  $display("FAIL %s: got gr=%0b ce=%0b temp=0x%0h flags=%b, expected gr=%0b ce=%0b temp=0x%0h flags=%b",
                           nm, Greset, cmd_err, STtemp, {STGas, STPeligro, STAlerta},
                           e.gr, e.ce, e.temp, e.flags);
               end
            end
            mon_temp  = STtemp;
            mon_flags = {STGas, STPeligro, STAlerta};
         end
      end
   end

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0;
      flag    = 1'b0;
      DATO    = 8'h00;
      m_temp  = '0;
      m_flags = '0;
      repeat (3) @(negedge CLK);
      check("rst_temp",    32'(STtemp), 32'h0);
      check("rst_flags",   32'({STGas, STPeligro, STAlerta}), 32'h0);
      check("rst_pulses",  32'({Greset, cmd_err}), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);

      // T 1 1 8 Enter -> channel 0 = 18
      seq = '{8'h2C, 8'h16, 8'h16, 8'h3E};
      run_seq();
      check("busy_partial", 32'(busy), 32'h1);
      m_temp = 16'h0012;
      expect_ev("temp_ch0_18", 1'b0, 1'b0);
      send(8'h5A);
      check("busy_after_enter", 32'(busy), 32'h0);

      // T 2 2 5 5 Enter -> channel 1 saturates to 255
      m_temp = 16'hFF12;
      expect_ev("temp_ch1_sat", 1'b0, 1'b0);
      seq = '{8'h2C, 8'h1E, 8'h1E, 8'h2E, 8'h2E, 8'h5A};
      run_seq();

      // Fourth digit -> ERR, one cmd_err at Enter, channel unchanged
      seq = '{8'h2C, 8'h1E, 8'h16, 8'h46, 8'h46, 8'h46};
      run_seq();
      check("busy_in_err", 32'(busy), 32'h1);
      expect_ev("too_many_digits", 1'b0, 1'b1);
      send(8'h5A);

      // A 1 Enter, then released A ignored
      m_flags = 3'b001;
      expect_ev("alerta_set", 1'b0, 1'b0);
      seq = '{8'h1C, 8'h16, 8'h5A, 8'hF0, 8'h1C};
      run_seq();
      check("break_ignored_busy", 32'(busy), 32'h0);

      // P E0 1 Enter -> extended prefix dropped
      m_flags = 3'b011;
      expect_ev("peligro_set_ext", 1'b0, 1'b0);
      seq = '{8'h4D, 8'hE0, 8'h16, 8'h5A};
      run_seq();

      m_flags = 3'b111;
      expect_ev("gas_set", 1'b0, 1'b0);
      seq = '{8'h34, 8'h16, 8'h5A};
      run_seq();

      m_flags = 3'b101;
      expect_ev("peligro_clear", 1'b0, 1'b0);
      seq = '{8'h4D, 8'h45, 8'h5A};
      run_seq();

      // R held for 20 cycles consumed once, then Enter -> one Greset pulse
      send(8'h2D, 20);
      check("busy_r_held", 32'(busy), 32'h1);
      expect_ev("greset_pulse", 1'b1, 1'b0);
      send(8'h5A);

      send(8'h5A);
      check("idle_enter_busy", 32'(busy), 32'h0);

      expect_ev("unknown_cmd", 1'b0, 1'b1);
      seq = '{8'h1B, 8'h16, 8'h2C, 8'h5A};
      run_seq();

      expect_ev("chan_out_of_range", 1'b0, 1'b1);
      seq = '{8'h2C, 8'h26, 8'h5A};
      run_seq();

      expect_ev("chan_zero", 1'b0, 1'b1);
      seq = '{8'h2C, 8'h45, 8'h5A};
      run_seq();

      expect_ev("zero_digits", 1'b0, 1'b1);
      seq = '{8'h2C, 8'h16, 8'h5A};
      run_seq();

      m_temp = 16'hFF06;
      expect_ev("single_digit", 1'b0, 1'b0);
      seq = '{8'h2C, 8'h16, 8'h36, 8'h5A};
      run_seq();

      expect_ev("flagv_bad", 1'b0, 1'b1);
      seq = '{8'h1C, 8'h1E, 8'h5A};
      run_seq();

      // Reset mid-command discards the partial entry
      seq = '{8'h2C, 8'h16, 8'h16};
      run_seq();
      RESET_N = 1'b0;
      m_temp  = '0;
      m_flags = '0;
      #1;
      check("midrst_temp",  32'(STtemp), 32'h0);
      check("midrst_flags", 32'({STGas, STPeligro, STAlerta}), 32'h0);
      check("midrst_busy",  32'(busy), 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      send(8'h5A);
      check("post_rst_temp", 32'(STtemp), 32'h0);
      check("post_rst_err",  32'(cmd_err), 32'h0);

      // Partial P 1 left idle
      seq = '{8'h4D, 8'h16};
`ifdef KBD_TIMEOUT_EN
      expect_ev("timeout_abort", 1'b0, 1'b1);
      run_seq();
      repeat (150) @(negedge CLK);
      check("timeout_busy", 32'(busy), 32'h0);
      send(8'h5A);
`else
      run_seq();
      repeat (150) @(negedge CLK);
      check("no_timeout_busy", 32'(busy), 32'h1);
      m_flags = 3'b010;
      expect_ev("late_commit", 1'b0, 1'b0);
      send(8'h5A);
`endif

      repeat (5) @(negedge CLK);
      check("sb_drained", 32'(ev_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
